cordic_vec: RTL and testbench
=============================

Name: cordic_vec

Overview:
- Iterative vectoring-mode CORDIC: takes a Cartesian point (x, y) and returns either its angle atan2(y, x) or its magnitude sqrt(x²+y²).
- It is the inverse direction of the pipelined rotation-mode cosine unit (angle in, coordinates out); this block takes coordinates in and returns an angle or magnitude out.
- Attached to the Nios II as a multicycle custom instruction (start/done handshake).
- Fixed-point datapath, one micro-rotation per cycle, no FP adders.

Parameters:
- N, 16, number of micro-rotations (legal range 8..24); sets accuracy and latency.
- W, 34, internal x/y datapath width; 32-bit input plus 2 guard bits for CORDIC gain and pre-rotation growth.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  Nios clock enable; when low, all registers hold.
- start  in  1  one-cycle request; operands valid in the same cycle.
- dataa  in  32  x, signed Q1.30.
- datab  in  32  y, signed Q1.30.
- n  in  1  0 = return angle; 1 = return magnitude.
- result  out  32  angle as signed Q3.29 radians, or magnitude as signed Q1.30.
- done  out  1  one-cycle pulse; result valid in that cycle and held afterwards.

Behaviour:
- Reset (reset=0, asynchronous) forces state=IDLE, result=0, done=0, and clears the iteration counter and x/y/z registers. Reset mid-operation aborts the operation with no done pulse.
- All state advances only on rising clk edges with clk_en=1. When clk_en=0, everything holds, including a pending done.
- States: IDLE -> PRE -> ITER -> SCALE -> IDLE.
- IDLE
  - done=0.
  - On start=1, capture x (dataa) and y (datab), both sign-extended to W bits; capture n; set z=0; go to PRE.
- start when not in IDLE is ignored. No queueing, no abort.
- PRE (1 cycle), quadrant correction:
  - If x≥0: no change.
  - If x<0 and y≥0: (x, y) <- (y, -x); z <- +pi/2 (0x3243F6A9).
  - If x<0 and y<0: (x, y) <- (-y, x); z <- -pi/2 (0xCDBC0957).
  - Next state ITER, i=0.
- ITER (N cycles, i = 0..N-1), shifts arithmetic:
  - If y≥0: x += y>>>i; y -= x>>>i; z += T[i].
  - Otherwise: x -= y>>>i; y += x>>>i; z -= T[i].
  - All three updates use the old x, y, z values.
  - T[i] = round(atan(2^-i)·2^29), 32-bit constant ROM; T[0]=0x1921FB54.
  - After i=N-1, go to SCALE.
- SCALE (1 cycle)
  - n=0: result <- z.
  - n=1: result <- (x · KINV) >>> 30, where KINV = 0x26DD3B6A (1/K, Q0.30). Saturate to [0x80000000, 0x7FFFFFFF].
  - done <- 1 for exactly this one output cycle; next state IDLE.
- Latency: done is high after the (N+2)th enabled edge following the edge that samples start; 18 edges at N=16. Throughput is one operation per N+3 enabled cycles; a new start is accepted in the cycle done is high.
- Boundary cases:
  - x=y=0: result is 0 for the magnitude (n=1); the angle (n=0) is don't-care, but must be deterministic with no X.
  - x=-1.0 (0xC0000000) negation must not overflow; it is handled by the W-bit guard bits.
  - Angle near ±pi may return either sign within tolerance.
- Accuracy at N=16: angle |err| ≤ 2^-14 rad (2^15 LSB); magnitude |err| ≤ 2^-14 (2^16 LSB).

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> result=0, done=0; no done pulse without start.
- x=y=0x10000000 (0.25), n=0 -> result ≈ 0x1921FB54 (pi/4) within tolerance; done exactly 18 edges after start. Repeat with n=1 -> ≈ 0x16A09E66 (0.35355).
- x=0xE0000000 (-0.5), y=0, n=0 -> ≈ 0x6487ED51 (pi). x=0, y=0xE0000000, n=0 -> ≈ 0xCDBC0957 (-pi/2).
- x=0x40000000, y=0, n=1 -> ≈ 0x40000000 (1.0). x=y=0xC0000000, n=1 -> ≈ 0x5A82799A (1.4142), no wrap.
- start pulsed again at cycle 5 of a busy operation with different operands -> ignored; first result unchanged; exactly one done. clk_en=0 for 7 cycles mid-ITER -> done delayed by exactly 7; same result.
- reset=0 asserted asynchronously mid-ITER -> result=0 and done=0 immediately; no done afterwards; next start works normally.

Source files
------------

// File: rtl/cordic_vec.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vec
// Purpose  : Iterative vectoring-mode CORDIC returning atan2(y, x) (Q3.29 rad)
//            or sqrt(x^2 + y^2) (Q1.30) as a multicycle custom instruction.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vec #(
  parameter int N = 16,
  parameter int W = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        n,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_ITER  = 2'd2,
    S_SCALE = 2'd3
  } state_t;

  localparam logic signed [31:0]   c_HALF_PI     = 32'sh3243F6A9;
  localparam logic signed [31:0]   c_NEG_HALF_PI = 32'shCDBC0957;
  localparam logic signed [W+31:0] c_KINV        = (W+32)'(32'h26DD3B6A);
  localparam logic [4:0]           c_LAST        = 5'(N - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [W-1:0]   r_x;
  logic signed [W-1:0]   r_y;
  logic signed [31:0]    r_z;
  logic [4:0]            r_iter;
  logic                  r_mode;

  logic signed [W-1:0]   w_x_sh;
  logic signed [W-1:0]   w_y_sh;
  logic signed [31:0]    w_t;
  logic signed [W+31:0]  w_x_ext;
  logic signed [W+31:0]  w_prod;
  logic signed [W+31:0]  w_scaled;
  logic                  w_fits;
  logic [31:0]           w_mag;

  // Arctangent table, atan(2^-i) scaled by 2^29 and rounded.
  function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
    logic signed [31:0] v;
    case (idx)
      5'd0:    v = 32'sh1921FB54;
      5'd1:    v = 32'sh0ED63383;
      5'd2:    v = 32'sh07D6DD7E;
      5'd3:    v = 32'sh03FAB753;
      5'd4:    v = 32'sh01FF55BB;
      5'd5:    v = 32'sh00FFEAAE;
      5'd6:    v = 32'sh007FFD55;
      5'd7:    v = 32'sh003FFFAB;
      5'd8:    v = 32'sh001FFFF5;
      5'd9:    v = 32'sh000FFFFF;
      5'd10:   v = 32'sh00080000;
      5'd11:   v = 32'sh00040000;
      5'd12:   v = 32'sh00020000;
      5'd13:   v = 32'sh00010000;
      5'd14:   v = 32'sh00008000;
      5'd15:   v = 32'sh00004000;
      5'd16:   v = 32'sh00002000;
      5'd17:   v = 32'sh00001000;
      5'd18:   v = 32'sh00000800;
      5'd19:   v = 32'sh00000400;
      5'd20:   v = 32'sh00000200;
      5'd21:   v = 32'sh00000100;
      5'd22:   v = 32'sh00000080;
      5'd23:   v = 32'sh00000040;
      default: v = 32'sh00000000;
    endcase
    return v;
  endfunction

  function automatic logic signed [W-1:0] sext(input logic [31:0] d);
    return {{(W-32){d[31]}}, d};
  endfunction

  assign w_x_sh = r_x >>> r_iter;
  assign w_y_sh = r_y >>> r_iter;
  assign w_t    = atan_rom(r_iter);

  // Gain compensation: x carries the CORDIC gain K, multiply by 1/K in Q0.30.
  assign w_x_ext  = {{32{r_x[W-1]}}, r_x};
  assign w_prod   = w_x_ext * c_KINV;
  assign w_scaled = w_prod >>> 30;
  assign w_fits   = (w_scaled[W+31:31] == {(W+1){1'b0}}) ||
                    (w_scaled[W+31:31] == {(W+1){1'b1}});
  assign w_mag    = w_fits ? w_scaled[31:0]
                           : (w_scaled[W+31] ? 32'h80000000 : 32'h7FFFFFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PRE;
      S_PRE:   w_state_nxt = S_ITER;
      S_ITER:  if (r_iter == c_LAST) w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_mode <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= sext(dataa);
            r_y    <= sext(datab);
            r_z    <= '0;
            r_mode <= n;
          end
        end
        S_PRE: begin
          r_iter <= '0;
          // Fold the left half-plane into the right so iterations converge.
          if (r_x[W-1]) begin
            if (!r_y[W-1]) begin
              r_x <= r_y;
              r_y <= -r_x;
              r_z <= c_HALF_PI;
            end else begin
              r_x <= -r_y;
              r_y <= r_x;
              r_z <= c_NEG_HALF_PI;
            end
          end
        end
        S_ITER: begin
          if (!r_y[W-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_t;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_t;
          end
          r_iter <= r_iter + 5'd1;
        end
        S_SCALE: begin
          result <= r_mode ? w_mag : r_z;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vec
// Purpose  : Directed self-checking bench for cordic_vec with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_vec;

  localparam real PI     = 3.141592653589793;
  localparam real TWO_PI = 6.283185307179586;
  localparam real TOL    = 1.0 / 16384.0;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        clk_en = 1'b1;
  logic        start  = 1'b0;
  logic [31:0] dataa  = '0;
  logic [31:0] datab  = '0;
  logic        n      = 1'b0;
  logic [31:0] result;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic mode;
    real  expv;
    bit   dc;
  } exp_t;

  exp_t sb[$];

  cordic_vec #(.N(16), .W(34)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .n      (n),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input real obs, input real exp);
    checks++;
    assert (((obs - exp) <= TOL) && ((exp - obs) <= TOL)) else begin
      failures++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  function automatic real q30(input logic [31:0] v);
    return $itor($signed(v)) / 1073741824.0;
  endfunction

  task automatic push_exp(input logic [31:0] x, input logic [31:0] y, input logic m);
    exp_t e;
    e.mode = m;
    e.dc   = (!m && x == 32'h0 && y == 32'h0);
    e.expv = m ? $sqrt(q30(x) * q30(x) + q30(y) * q30(y)) : $atan2(q30(y), q30(x));
    sb.push_back(e);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk_eq(tag, 32'(seen), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic m, input int intrude_at, input int stall_at,
                        input int stall_len, input int exp_lat);
    int          edges;
    exp_t        e;
    real         obs, d;
    logic [31:0] held;
    @(negedge clk);
    dataa = x;
    datab = y;
    n     = m;
    start = 1'b1;
    push_exp(x, y, m);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      start = (edges == intrude_at);
      if (start) begin
        dataa = 32'h7FFF0000;
        datab = 32'h80010000;
        n     = ~m;
      end
      clk_en = !(edges >= stall_at && edges < stall_at + stall_len);
      @(negedge clk);
      edges++;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    n      = m;
    chk_eq({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    chk_eq({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      if (e.dc) begin
        chk_eq({tag, "_known"}, 32'($isunknown(result)), 32'd0);
      end else if (e.mode) begin
        chk_tol({tag, "_mag"}, q30(result), e.expv);
      end else begin
        obs = $itor($signed(result)) / 536870912.0;
        d   = obs - e.expv;
        if (d > PI)  obs = obs - TWO_PI;
        if (d < -PI) obs = obs + TWO_PI;
        chk_tol({tag, "_ang"}, obs, e.expv);
      end
    end
    held = result;
    @(negedge clk);
    chk_eq({tag, "_pulse"}, 32'(done), 32'd0);
    chk_eq({tag, "_held"}, result, held);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_eq("reset_result", result, 32'h0);
    chk_eq("reset_done", 32'(done), 32'd0);
    no_done("idle_no_done", 10);

    run_op("q1_angle",   32'h10000000, 32'h10000000, 1'b0, -1, 1000, 0, 18);
    run_op("q1_mag",     32'h10000000, 32'h10000000, 1'b1, -1, 1000, 0, 18);
    run_op("neg_x_pi",   32'hE0000000, 32'h00000000, 1'b0, -1, 1000, 0, 18);
    run_op("neg_y",      32'h00000000, 32'hE0000000, 1'b0, -1, 1000, 0, 18);
    run_op("q2_angle",   32'hECCCCCCD, 32'h26666666, 1'b0, -1, 1000, 0, 18);
    run_op("q3_angle",   32'hD0000000, 32'hF0000000, 1'b0, -1, 1000, 0, 18);
    run_op("unit_mag",   32'h40000000, 32'h00000000, 1'b1, -1, 1000, 0, 18);
    run_op("minus1_mag", 32'hC0000000, 32'hC0000000, 1'b1, -1, 1000, 0, 18);
    run_op("zero_mag",   32'h00000000, 32'h00000000, 1'b1, -1, 1000, 0, 18);
    chk_eq("zero_mag_exact", result, 32'h0);
    run_op("zero_ang",   32'h00000000, 32'h00000000, 1'b0, -1, 1000, 0, 18);

    run_op("busy_start", 32'h30000000, 32'h10000000, 1'b0, 5, 1000, 0, 18);
    no_done("busy_single_done", 25);

    run_op("stall",      32'h20000000, 32'hD0000000, 1'b1, -1, 5, 7, 25);

    // Abort mid-iteration; result still holds the previous magnitude.
    @(negedge clk);
    dataa = 32'h18000000;
    datab = 32'h08000000;
    n     = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_eq("areset_result", result, 32'h0);
    chk_eq("areset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    no_done("areset_no_done", 25);

    run_op("post_reset", 32'h12345678, 32'h0ABCDEF0, 1'b0, -1, 1000, 0, 18);
    run_op("post_mag",   32'h12345678, 32'h0ABCDEF0, 1'b1, -1, 1000, 0, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
